// File: rtl/hex_scroll_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_monitor
//  Description : Reader-side monitor for a six-digit scrolling seven-segment
//                display. On every display update step it checks that the
//                display moved by exactly one digit in the direction set by
//                DIR. It decodes the glyph that entered the display into a
//                5-bit character code and pushes that code into a small FIFO
//                for host/debug logic to drain.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH      FIFO entries (power of two, 2..32)
//    DIR        0: glyphs enter at hex0 and move toward hex5
//               1: glyphs enter at hex5 and move toward hex0
//    LOCK_STEPS consecutive good steps needed to raise locked (1..15)
//  Ports
//    clk        system clock, rising edge
//    reset      synchronous reset, active low
//    step       display update strobe; hex0..hex5 already hold new values
//    hex0..hex5 active-low segment patterns, bit0 = a ... bit6 = g
//    rd_en      FIFO pop request (ignored while empty)
//    rd_data    registered popped character code
//    empty/full FIFO status
//    overflow   sticky: a write was dropped because the FIFO was full
//    char_valid one-cycle pulse, new character decoded
//    char_code  last decoded character code (holds between pulses)
//    shift_err  one-cycle pulse, step was not a one-digit shift
//    decode_err one-cycle pulse, entering glyph not in the glyph table
//    err_count  saturating count of shift errors
//    locked     LOCK_STEPS consecutive good steps seen
// ============================================================================
module hex_scroll_monitor #(
    parameter int DEPTH      = 8,
    parameter int DIR        = 0,
    parameter int LOCK_STEPS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [6:0] hex4,
    input  logic [6:0] hex5,
    input  logic       rd_en,
    output logic [4:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       char_valid,
    output logic [4:0] char_code,
    output logic       shift_err,
    output logic       decode_err,
    output logic [3:0] err_count,
    output logic       locked
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_FULL   = (AW+1)'(DEPTH);
    localparam logic [3:0] c_LOCK    = 4'(LOCK_STEPS);
    localparam logic [4:0] c_BAD_GLYPH = 5'd31;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    state_t        r_state;
    logic [6:0]    w_hex   [6];
    // Only the five digits that the next step will be compared against are
    // remembered; the digit that is about to scroll off is never needed.
    logic [6:0]    w_keep  [5];
    logic [6:0]    w_cmp   [5];
    logic [6:0]    r_snap  [5];
    logic [6:0]    w_enter;
    logic [4:0]    w_code;
    logic          w_shift_ok;

    logic [4:0]    r_mem   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [4:0]    r_rd_data;
    logic          r_overflow;
    logic          r_char_valid;
    logic [4:0]    r_char_code;
    logic          r_shift_err;
    logic          r_decode_err;
    logic [3:0]    r_err_count;
    logic          r_locked;
    logic [3:0]    r_good_cnt;

    logic          w_step_track;
    logic          w_good;
    logic          w_bad;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_hex[0] = hex0;
    assign w_hex[1] = hex1;
    assign w_hex[2] = hex2;
    assign w_hex[3] = hex3;
    assign w_hex[4] = hex4;
    assign w_hex[5] = hex5;

    // r_snap[i] holds the old digit that should now appear in w_cmp[i].
    generate
        if (DIR == 0) begin : g_dir_up
            for (genvar gi = 0; gi < 5; gi++) begin : g_pair
                assign w_keep[gi] = w_hex[gi];
                assign w_cmp[gi]  = w_hex[gi+1];
            end
            assign w_enter = hex0;
        end else begin : g_dir_down
            for (genvar gi = 0; gi < 5; gi++) begin : g_pair
                assign w_keep[gi] = w_hex[gi+1];
                assign w_cmp[gi]  = w_hex[gi];
            end
            assign w_enter = hex5;
        end
    endgenerate

    always_comb begin
        w_shift_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (w_cmp[i] != r_snap[i]) begin
                w_shift_ok = 1'b0;
            end
        end
    end

    always_comb begin
        case (w_enter)
            7'b1000000: w_code = 5'd0;
            7'b1111001: w_code = 5'd1;
            7'b0100100: w_code = 5'd2;
            7'b0110000: w_code = 5'd3;
            7'b0011001: w_code = 5'd4;
            7'b0010010: w_code = 5'd5;
            7'b0000010: w_code = 5'd6;
            7'b1111000: w_code = 5'd7;
            7'b0000000: w_code = 5'd8;
            7'b0010000: w_code = 5'd9;
            7'b0001000: w_code = 5'd10;
            7'b0000011: w_code = 5'd11;
            7'b1000110: w_code = 5'd12;
            7'b0100001: w_code = 5'd13;
            7'b0000110: w_code = 5'd14;
            7'b0001110: w_code = 5'd15;
            7'b1111111: w_code = 5'd16;
            default:    w_code = c_BAD_GLYPH;
        endcase
    end

    assign w_step_track = reset && step && (r_state == S_TRACK);
    assign w_good       = w_step_track && w_shift_ok;
    assign w_bad        = w_step_track && !w_shift_ok;
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_FULL);
    // A flush on the same edge takes priority over a pop.
    assign w_pop        = rd_en && !w_empty && !w_bad;
    // When full, a write only fits if a pop frees a slot on the same edge.
    assign w_push       = w_good && (!w_full || w_pop);
    assign w_drop       = w_good && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < 5; i++) begin
                r_snap[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rd_data    <= '0;
            r_overflow   <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_code  <= '0;
            r_shift_err  <= 1'b0;
            r_decode_err <= 1'b0;
            r_err_count  <= '0;
            r_locked     <= 1'b0;
            r_good_cnt   <= '0;
        end else begin
            r_char_valid <= 1'b0;
            r_shift_err  <= 1'b0;
            r_decode_err <= 1'b0;

            if (step) begin
                for (int i = 0; i < 5; i++) begin
                    r_snap[i] <= w_keep[i];
                end
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_TRACK;
                    end
                    S_TRACK: begin
                        if (w_shift_ok) begin
                            r_char_valid <= 1'b1;
                            r_char_code  <= w_code;
                            r_decode_err <= (w_code == c_BAD_GLYPH);
                            if (r_good_cnt != c_LOCK) begin
                                r_good_cnt <= r_good_cnt + 4'd1;
                            end
                            if (r_good_cnt >= c_LOCK - 4'd1) begin
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_shift_err <= 1'b1;
                            if (r_err_count != 4'hF) begin
                                r_err_count <= r_err_count + 4'd1;
                            end
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end

            if (w_bad) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr  <= r_rd_ptr + 1'b1;
                    r_rd_data <= r_mem[r_rd_ptr];
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign char_valid = r_char_valid;
    assign char_code  = r_char_code;
    assign shift_err  = r_shift_err;
    assign decode_err = r_decode_err;
    assign err_count  = r_err_count;
    assign locked     = r_locked;

endmodule
`default_nettype wire
